// File: rtl/uart_resp_pkg.sv
// Shared encodings for the UART protocol responder: FSM states and reply modes.
package uart_resp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_e;

    localparam int MODE_FIXED      = 0;
    localparam int MODE_ECHO       = 1;
    localparam int MODE_ECHO_FIXED = 2;

    // Number of bytes transmitted for one request in the given mode.
    function automatic int seq_len(input int mode, input int resp_len);
        if (mode == MODE_ECHO)
            return 1;
        else if (mode == MODE_ECHO_FIXED)
            return resp_len + 1;
        else
            return resp_len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request FIFO. Head is read combinationally so the consumer can
// pop and capture in the same cycle; a push and pop together are accepted
// even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push needs, so full does not block it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                level_q <= level_q + 1'b1;
            else if (do_pop && !do_push)
                level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_responder.sv
// UART protocol responder: queues received bytes and answers each with a fixed
// string, an echo, or an echo followed by the fixed string, handshaking every
// byte with the transmitter's busy flag.
// Optional macro RESP_TIMEOUT_EN: abandon a sequence when tx_busy never rises
// within TIMEOUT cycles of a strobe, pulsing tx_timeout.
module uart_responder
    import uart_resp_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MODE      = 0,
    parameter int          RESP_LEN  = 1,
    parameter logic [63:0] RESP_DATA = 64'h38,
    parameter int          TIMEOUT   = 24000,
    localparam int         LW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_error,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          busy,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    input  logic          clr_overflow
`ifdef RESP_TIMEOUT_EN
    ,
    output logic          tx_timeout
`endif
);

    localparam int         SEQ_LEN = seq_len(MODE, RESP_LEN);
    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    state_e     state_q;
    logic [7:0] req_q;
    logic [3:0] idx_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic       overflow_q;

    logic       push_req;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] sel_idx;
    logic [7:0] sel_req;
    logic [7:0] tx_data_d;

    assign push_req = rx_valid && !rx_error;
    assign fifo_pop = (state_q == LOAD);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (fifo_pop),
        .din_i   (rx_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Byte at position idx of the reply sequence for request byte req.
    function automatic logic [7:0] pick_byte(input logic [7:0] req, input logic [3:0] idx);
        logic [2:0] fidx;
        logic [7:0] b;
        fidx = (MODE == MODE_ECHO_FIXED) ? 3'(idx - 4'd1) : idx[2:0];
        b    = RESP_DATA[{fidx, 3'b000} +: 8];
        if (MODE == MODE_ECHO)
            b = req;
        else if ((MODE == MODE_ECHO_FIXED) && (idx == 4'd0))
            b = req;
        return b;
    endfunction

    // Next byte to load: first byte straight from the FIFO head in LOAD, else the following index.
    always_comb begin
        sel_idx   = (state_q == LOAD) ? 4'd0 : idx_q + 4'd1;
        sel_req   = (state_q == LOAD) ? fifo_dout : req_q;
        tx_data_d = pick_byte(sel_req, sel_idx);
    end

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmo_cnt_q;
    logic          tx_timeout_q;
    assign tx_timeout = tx_timeout_q;
`endif

    // Transmit sequencer with registered strobe and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef RESP_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            tx_timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !tx_busy)
                        state_q <= LOAD;
                end
                LOAD: begin
                    req_q      <= fifo_dout;
                    idx_q      <= '0;
                    tx_data_q  <= tx_data_d;
                    tx_start_q <= 1'b1;
                    state_q    <= START;
                end
                START: begin
`ifdef RESP_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy)
                        state_q <= WAIT_LO;
`ifdef RESP_TIMEOUT_EN
                    else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        tx_timeout_q <= 1'b1;
                        state_q      <= IDLE;
                    end else
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx_q == LAST_IDX)
                            state_q <= IDLE;
                        else begin
                            idx_q      <= idx_q + 4'd1;
                            tx_data_q  <= tx_data_d;
                            tx_start_q <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow_q <= 1'b0;
        else if (push_req && fifo_full && !fifo_pop)
            overflow_q <= 1'b1;
        else if (clr_overflow)
            overflow_q <= 1'b0;
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_responder.sv
// Scoreboard bench for uart_responder: three instances (fixed, echo, echo+fixed),
// each with a tx_busy model; expected bytes are queued at stimulus time and
// popped by per-instance monitors on every tx_start.
module tb_uart_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- instance 0: MODE 0, fixed 8'h38 ----------------
    logic       rxv0 = 0, rxe0 = 0, clr0 = 0;
    logic [7:0] rxd0 = 0, txd0;
    logic       txs0, bsy0, ovf0, txb0;
    logic [2:0] lvl0;
    int         bcnt0 = 0, ntx0 = 0;
    logic [7:0] exp0[$];
    int         expc0[$];
`ifdef RESP_TIMEOUT_EN
    logic       tmo0;
`endif

    uart_responder #(.DEPTH(4), .MODE(0), .RESP_LEN(1), .RESP_DATA(64'h38), .TIMEOUT(16)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv0), .rx_data(rxd0), .rx_error(rxe0),
        .tx_busy(txb0), .tx_start(txs0), .tx_data(txd0), .busy(bsy0),
        .fifo_level(lvl0), .overflow(ovf0), .clr_overflow(clr0)
`ifdef RESP_TIMEOUT_EN
        , .tx_timeout(tmo0)
`endif
    );

    // ---------------- instance 1: MODE 1, echo ----------------
    logic       rxv1 = 0, rxe1 = 0, clr1 = 0;
    logic [7:0] rxd1 = 0, txd1;
    logic       txs1, bsy1, ovf1, txb1;
    logic [2:0] lvl1;
    int         bcnt1 = 0, ntx1 = 0;
    logic       force1 = 0, stuck1 = 0;
    logic [7:0] exp1[$];
`ifdef RESP_TIMEOUT_EN
    logic       tmo1;
    int         ntmo1 = 0, last_start1 = 0, last_tmo1 = 0;
    logic       after_tmo1 = 0;
`endif

    uart_responder #(.DEPTH(4), .MODE(1), .RESP_LEN(1), .RESP_DATA(64'h38), .TIMEOUT(16)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv1), .rx_data(rxd1), .rx_error(rxe1),
        .tx_busy(txb1), .tx_start(txs1), .tx_data(txd1), .busy(bsy1),
        .fifo_level(lvl1), .overflow(ovf1), .clr_overflow(clr1)
`ifdef RESP_TIMEOUT_EN
        , .tx_timeout(tmo1)
`endif
    );

    // ---------------- instance 2: MODE 2, echo + CR LF ----------------
    logic       rxv2 = 0, rxe2 = 0, clr2 = 0;
    logic [7:0] rxd2 = 0, txd2;
    logic       txs2, bsy2, ovf2, txb2;
    logic [2:0] lvl2;
    int         bcnt2 = 0;
    logic [7:0] exp2[$];
    logic [7:0] last2 = 0;
`ifdef RESP_TIMEOUT_EN
    logic       tmo2;
`endif

    uart_responder #(.DEPTH(4), .MODE(2), .RESP_LEN(2), .RESP_DATA(64'h0A0D), .TIMEOUT(16)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv2), .rx_data(rxd2), .rx_error(rxe2),
        .tx_busy(txb2), .tx_start(txs2), .tx_data(txd2), .busy(bsy2),
        .fifo_level(lvl2), .overflow(ovf2), .clr_overflow(clr2)
`ifdef RESP_TIMEOUT_EN
        , .tx_timeout(tmo2)
`endif
    );

    // Transmitter models: busy for 10 cycles after each strobe.
    always @(posedge clk) begin
        if (txs0) bcnt0 <= 10; else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
        if (txs1 && !stuck1) bcnt1 <= 10; else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
        if (txs2) bcnt2 <= 10; else if (bcnt2 != 0) bcnt2 <= bcnt2 - 1;
    end
    assign txb0 = (bcnt0 != 0);
    assign txb1 = force1 | (bcnt1 != 0);
    assign txb2 = (bcnt2 != 0);

    // Monitors
    always @(negedge clk) begin
        if (rst_n && txs0) begin
            ntx0++;
            if (exp0.size() == 0)
                chk("u0_unexpected_tx_start", 1, 0);
            else begin
                chk("u0_tx_data", txd0, exp0.pop_front());
                chk("u0_latency_cycle", cyc, expc0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && txs1) begin
            ntx1++;
            if (exp1.size() == 0)
                chk("u1_unexpected_tx_start", 1, 0);
            else
                chk("u1_tx_data", txd1, exp1.pop_front());
`ifdef RESP_TIMEOUT_EN
            // After a timeout abort the FSM is IDLE, so the next strobe is IDLE->LOAD->START.
            if (after_tmo1) begin
                chk("u1_restart_after_timeout", cyc - last_tmo1, 2);
                after_tmo1 = 0;
            end
            last_start1 = cyc;
`endif
        end
`ifdef RESP_TIMEOUT_EN
        // Strobe at cycle S, WAIT_HI spans S+1..S+16 (counter 0..15), pulse in S+17.
        if (rst_n && tmo1) begin
            ntmo1++;
            chk("u1_timeout_delay", cyc - last_start1, 17);
            last_tmo1  = cyc;
            after_tmo1 = 1;
        end
`endif
    end

    always @(negedge clk) begin
        if (rst_n && txs2) begin
            chk("u2_tx_while_busy", txb2, 0);
            if (exp2.size() == 0)
                chk("u2_unexpected_tx_start", 1, 0);
            else
                chk("u2_tx_data", txd2, exp2.pop_front());
            last2 = txd2;
        end else if (rst_n && txb2) begin
            chk("u2_tx_data_hold", txd2, last2);
        end
    end

    // Stimulus tasks: called at a negedge, return at the next negedge.
    task automatic send0(input logic [7:0] d, input logic e);
        rxd0 = d; rxe0 = e; rxv0 = 1;
        @(negedge clk);
        rxv0 = 0; rxe0 = 0;
    endtask

    task automatic send1(input logic [7:0] d);
        rxd1 = d; rxv1 = 1;
        @(negedge clk);
        rxv1 = 0;
    endtask

    task automatic send2(input logic [7:0] d);
        rxd2 = d; rxv2 = 1;
        @(negedge clk);
        rxv2 = 0;
    endtask

    task automatic wait_txs1(input int budget);
        int n = 0;
        while (!txs1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!txs1) chk("u1_wait_tx_start_timeout", 0, 1);
    endtask

    int n_before;

    initial begin
        rst_n = 0;
        #12;
        chk("rst_u0_tx_start", txs0, 0);
        chk("rst_u0_tx_data", txd0, 0);
        chk("rst_u0_busy", bsy0, 0);
        chk("rst_u1_fifo_level", lvl1, 0);
        chk("rst_u1_overflow", ovf1, 0);
        chk("rst_u2_tx_data", txd2, 0);
`ifdef RESP_TIMEOUT_EN
        chk("rst_u1_tx_timeout", tmo1, 0);
`endif
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Fixed reply: 8'h41 answered by 8'h38, strobe visible three edges after the push.
        exp0.push_back(8'h38);
        send0(8'h41, 1'b0);
        expc0.push_back(cyc + 2);
        repeat (25) @(negedge clk);
        chk("u0_tx_count", ntx0, 1);

        // Errored byte is discarded.
        send0(8'hFF, 1'b1);
        chk("u0_err_fifo_level", lvl0, 0);
        repeat (10) @(negedge clk);
        chk("u0_err_no_tx", ntx0, 1);
        chk("u0_err_busy", bsy0, 0);

        // Echo + CR LF: 5A, 0D, 0A.
        exp2.push_back(8'h5A);
        exp2.push_back(8'h0D);
        exp2.push_back(8'h0A);
        send2(8'h5A);
        repeat (60) @(negedge clk);
        chk("u2_seq_done", exp2.size(), 0);
        chk("u2_idle", bsy2, 0);

        // Overflow: first byte goes out, transmitter then held busy, 02..05 queued, 06 dropped.
        exp1.push_back(8'h01);
        send1(8'h01);
        wait_txs1(10);
        force1 = 1;
        @(negedge clk);
        for (int i = 2; i <= 6; i++) begin
            if (i <= 5) exp1.push_back(8'(i));
            send1(8'(i));
        end
        chk("u1_full_level", lvl1, 4);
        chk("u1_overflow_set", ovf1, 1);
        repeat (5) @(negedge clk);
        force1 = 0;
        repeat (100) @(negedge clk);
        chk("u1_echo_done", exp1.size(), 0);
        chk("u1_overflow_sticky", ovf1, 1);
        clr1 = 1;
        @(negedge clk);
        clr1 = 0;
        chk("u1_overflow_cleared", ovf1, 0);

`ifdef RESP_TIMEOUT_EN
        // Transmitter never acknowledges: both requests time out, one after the other.
        stuck1 = 1;
        exp1.push_back(8'h11);
        exp1.push_back(8'h22);
        send1(8'h11);
        send1(8'h22);
        repeat (60) @(negedge clk);
        chk("u1_timeout_count", ntmo1, 2);
        chk("u1_timeout_served", exp1.size(), 0);
        chk("u1_timeout_idle", bsy1, 0);
        stuck1 = 0;
        repeat (2) @(negedge clk);
`endif

        // Reset mid-sequence in WAIT_LO with two bytes queued.
        exp1.push_back(8'h33);
        send1(8'h33);
        wait_txs1(10);
        @(negedge clk);
        send1(8'h44);
        send1(8'h55);
        @(negedge clk);
        chk("u1_pre_reset_level", lvl1, 2);
        n_before = ntx1;
        #2 rst_n = 0;
        #1;
        chk("u1_async_rst_level", lvl1, 0);
        chk("u1_async_rst_tx_start", txs1, 0);
        chk("u1_async_rst_busy", bsy1, 0);
        chk("u1_async_rst_tx_data", txd1, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        chk("u1_no_tx_after_reset", ntx1 - n_before, 0);
        chk("u1_idle_after_reset", bsy1, 0);

        chk("u0_queue_empty", exp0.size(), 0);
        chk("u1_queue_empty", exp1.size(), 0);
        chk("u2_queue_empty", exp2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
